// File: rtl/la_capture_seq.sv
// Logic-analyser capture sequencer: arms, fills the pre-trigger ring, waits for the
// trigger, records the post-trigger window and holds a complete frame for display.
module la_capture_seq #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int PRE_DEPTH = 1024
) (
    input  logic              iSysClk,
    input  logic              iRst,
    input  logic              clk_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              arm,
    input  logic              abort,
    input  logic              auto_mode,
    input  logic              force_trig,
    input  logic              trigger_en,
    input  logic [2:0]        chn_sel,
    input  logic [2:0]        mode_sel,
    input  logic              frame_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state
);

    localparam int DEPTH      = 1 << ADDR_W;
    localparam int POST_DEPTH = DEPTH - PRE_DEPTH;
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_DEPTH);
    localparam logic [ADDR_W:0]   PRE_LAST  = (ADDR_W+1)'(PRE_DEPTH - 1);
    localparam logic [ADDR_W:0]   POST_LAST = (ADDR_W+1)'(POST_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } st_t;

    st_t               st;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic              ten_l;
    logic [2:0]        chn_l;
    logic [2:0]        mode_l;
    logic              prev_bit;
    logic              prev_valid;
    logic              force_seen;

    logic sample, s, hit, fire, rearm;

    assign sample = clk_en && (st == S_PRE || st == S_WAIT || st == S_POST);
    assign s      = data_in[chn_l];
    assign rearm  = (arm && (st == S_IDLE || st == S_DONE)) ||
                    (st == S_DONE && frame_ack && auto_mode);

    // Edge modes stay quiet until a previous sample exists for this capture.
    always_comb begin
        hit = 1'b0;
        case (mode_l)
            3'd0:    hit = prev_valid & ~prev_bit & s;
            3'd1:    hit = prev_valid & prev_bit & ~s;
            3'd2:    hit = s;
            3'd3:    hit = ~s;
            3'd4:    hit = prev_valid & (prev_bit ^ s);
            default: hit = 1'b0;
        endcase
    end

    assign fire = hit | ~ten_l | force_seen | force_trig;

    assign state = st;
    assign busy  = (st == S_PRE) || (st == S_WAIT) || (st == S_POST);
    assign done  = (st == S_DONE);

    always_ff @(posedge iSysClk or negedge iRst) begin
        if (!iRst) begin
            st         <= S_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            ten_l      <= 1'b0;
            chn_l      <= '0;
            mode_l     <= '0;
            prev_bit   <= 1'b0;
            prev_valid <= 1'b0;
            force_seen <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            wr_en <= 1'b0;
            if (abort) begin
                st         <= S_IDLE;
                force_seen <= 1'b0;
            end else if (rearm) begin
                st         <= S_PRE;
                ten_l      <= trigger_en;
                chn_l      <= chn_sel;
                mode_l     <= mode_sel;
                ptr        <= '0;
                cnt        <= '0;
                prev_bit   <= 1'b0;
                prev_valid <= 1'b0;
                force_seen <= 1'b0;
            end else begin
                // A force between samples is held and consumed by the next sample.
                if (st == S_WAIT && force_trig)
                    force_seen <= 1'b1;
                if (sample) begin
                    wr_en      <= 1'b1;
                    wr_data    <= data_in;
                    wr_addr    <= ptr;
                    ptr        <= ptr + 1'b1;
                    prev_bit   <= s;
                    prev_valid <= 1'b1;
                    force_seen <= 1'b0;
                    case (st)
                        S_PRE: begin
                            if (cnt == PRE_LAST) begin
                                st  <= S_WAIT;
                                cnt <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        S_WAIT: begin
                            if (fire) begin
                                trig_addr <= ptr;
                                cnt       <= (ADDR_W+1)'(1);
                                if (POST_DEPTH == 1) begin
                                    st         <= S_DONE;
                                    start_addr <= ptr - PRE_OFS;
                                end else begin
                                    st <= S_POST;
                                end
                            end
                        end
                        S_POST: begin
                            if (cnt == POST_LAST) begin
                                st         <= S_DONE;
                                start_addr <= trig_addr - PRE_OFS;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_la_capture_seq.sv
// Bench for la_capture_seq: a cycle vector table, directed multi-cycle scenarios and
// randomized captures checked against a sample-stream model of the frame contents.
module tb_la_capture_seq;
    localparam int AW = 6, DW = 8, PRE = 16, DEPTH = 64, POST = 48;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          clk_en = 0, arm = 0, abort = 0, auto_mode = 0, force_trig = 0;
    logic          trigger_en = 0, frame_ack = 0;
    logic [DW-1:0] data_in = '0;
    logic [2:0]    chn_sel = '0, mode_sel = '0;
    logic [AW-1:0] wr_addr, trig_addr, start_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en, busy, done;
    logic [2:0]    state;

    la_capture_seq #(.ADDR_W(AW), .DATA_W(DW), .PRE_DEPTH(PRE)) dut (
        .iSysClk(clk), .iRst(rst_n), .clk_en(clk_en), .data_in(data_in), .arm(arm),
        .abort(abort), .auto_mode(auto_mode), .force_trig(force_trig),
        .trigger_en(trigger_en), .chn_sel(chn_sel), .mode_sel(mode_sel),
        .frame_ack(frame_ack), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .trig_addr(trig_addr), .start_addr(start_addr), .busy(busy), .done(done),
        .state(state)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0, k_res = 0;
    logic [AW+DW-1:0] wq[$];
    logic [DW-1:0]    smp[$];
    logic             last_ce = 1'b0;

    // Write monitor: every write is logged and must follow a sampled cycle.
    always @(negedge clk) begin
        if (wr_en) begin
            wq.push_back({wr_addr, wr_data});
            nvec++;
            if (!last_ce) begin
                nerr++;
                $display("FAIL wr_latency: wr_en=1 but clk_en was 0 on the previous cycle");
            end
        end
        last_ce = clk_en;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit fire_ref(input logic [2:0] md, input bit p, input bit s);
        case (md)
            3'd0:    return !p && s;
            3'd1:    return p && !s;
            3'd2:    return s;
            3'd3:    return !s;
            3'd4:    return p != s;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] pattern(input int pat, input int idx);
        case (pat)
            1:       return (idx >= 40) ? 8'h08 : 8'h00;
            2:       return (idx >= 5) ? 8'h01 : 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    // One full capture; the expected frame is derived from the recorded sample stream.
    task automatic capture(input bit ten, input logic [2:0] md, input logic [2:0] ch,
                           input int gap, input int pat, input int force_at, input bit rnd_force);
        int base, fmin, k, n;
        bit fin, forced;
        logic [AW+DW-1:0] w;
        trigger_en = ten; mode_sel = md; chn_sel = ch; clk_en = 0; arm = 1;
        step();
        arm = 0;
        trigger_en = 1'($urandom); mode_sel = 3'($urandom); chn_sel = 3'($urandom);
        base = wq.size(); smp.delete(); fmin = 1 << 30; fin = 0; forced = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            clk_en     = (gap > 0) ? (cyc % gap == 0) : ($urandom_range(3) != 0);
            data_in    = pattern(pat, smp.size());
            force_trig = 0;
            if ((force_at >= 0 && !forced && smp.size() >= force_at) ||
                (rnd_force && ($urandom_range(49) == 0 || cyc == 400))) begin
                force_trig = 1;
                forced = 1;
                if (smp.size() >= PRE && smp.size() < fmin) fmin = smp.size();
            end
            if (clk_en) smp.push_back(data_in);
            step();
            fin = done;
        end
        force_trig = 0;
        if (!fin) begin
            nvec++; nerr++;
            $display("FAIL capture_timeout: done never rose, %0d samples", smp.size());
            clk_en = 0;
            return;
        end
        for (int i = 0; i < 5; i++) begin
            clk_en = 1; data_in = 8'($urandom);
            step();
        end
        clk_en = 0;
        step(); step();
        k = -1;
        for (int j = PRE; j < smp.size() && k < 0; j++)
            if (!ten || j >= fmin || fire_ref(md, smp[j-1][ch], smp[j][ch])) k = j;
        if (k < 0) begin
            nvec++; nerr++;
            $display("FAIL model_trigger: no trigger sample found in %0d samples", smp.size());
            return;
        end
        n = k + POST;
        chk("write_count", wq.size() - base, n);
        for (int j = 0; j < n && base + j < wq.size(); j++) begin
            w = wq[base + j];
            chk("wr_addr", w[AW+DW-1:DW], j % DEPTH);
            chk("wr_data", w[DW-1:0], smp[j]);
        end
        chk("trig_addr", trig_addr, k % DEPTH);
        chk("start_addr", start_addr, (k - PRE + DEPTH) % DEPTH);
        chk("done_state", state, 4);
        chk("done_flag", {busy, done, wr_en}, 3'b010);
        k_res = k;
    endtask

    typedef struct {
        bit arm, abort, ce;
        logic [7:0] d;
        logic [2:0] st;
        bit bs, we;
        logic [5:0] wa;
        logic [7:0] wd;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int base;
        logic [AW+DW-1:0] w;
        tbl[0] = '{1, 0, 0, 8'h00, 3'd1, 1, 0, 6'd0, 8'h00};
        tbl[1] = '{0, 0, 1, 8'hA5, 3'd1, 1, 1, 6'd0, 8'hA5};
        tbl[2] = '{0, 0, 0, 8'h00, 3'd1, 1, 0, 6'd0, 8'h00};
        tbl[3] = '{0, 0, 1, 8'h3C, 3'd1, 1, 1, 6'd1, 8'h3C};
        tbl[4] = '{1, 0, 1, 8'h77, 3'd1, 1, 1, 6'd2, 8'h77};
        tbl[5] = '{1, 1, 1, 8'h11, 3'd0, 0, 0, 6'd0, 8'h00};
        tbl[6] = '{0, 0, 1, 8'h22, 3'd0, 0, 0, 6'd0, 8'h00};
        tbl[7] = '{1, 0, 1, 8'h33, 3'd1, 1, 0, 6'd0, 8'h00};
        tbl[8] = '{0, 0, 1, 8'h44, 3'd1, 1, 1, 6'd0, 8'h44};
        tbl[9] = '{0, 1, 0, 8'h00, 3'd0, 0, 0, 6'd0, 8'h00};

        step(); step();
        chk("rst_state", state, 0);
        chk("rst_flags", {busy, done, wr_en}, 0);
        chk("rst_wr", {wr_addr, wr_data}, 0);
        chk("rst_addrs", {trig_addr, start_addr}, 0);
        rst_n = 1;
        step();

        foreach (tbl[i]) begin
            arm = tbl[i].arm; abort = tbl[i].abort; clk_en = tbl[i].ce; data_in = tbl[i].d;
            step();
            arm = 0; abort = 0; clk_en = 0;
            chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bs);
            chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].we);
            if (tbl[i].we) chk($sformatf("tbl%0d_wr", i), {wr_addr, wr_data}, {tbl[i].wa, tbl[i].wd});
        end

        capture(0, 3'd0, 3'd0, 1, 0, -1, 0);
        chk("t1_trig", trig_addr, 16);
        chk("t1_start", start_addr, 0);

        capture(1, 3'd0, 3'd3, 1, 1, -1, 0);
        chk("t2_trig", trig_addr, 40);
        chk("t2_start", start_addr, 24);
        w = wq[wq.size()-1];
        chk("t2_last_addr", w[AW+DW-1:DW], 23);

        capture(1, 3'd0, 3'd0, 2, 2, 30, 0);
        chk("t3_force_k", k_res, 30);

        capture(0, 3'd0, 3'd0, 4, 0, -1, 0);
        chk("t4_trig", trig_addr, 16);

        auto_mode = 1;
        capture(0, 3'd0, 3'd0, 1, 0, -1, 0);
        frame_ack = 1; step(); frame_ack = 0;
        chk("auto_rearm_state", state, 1);
        clk_en = 1; data_in = 8'h5A; step(); clk_en = 0;
        chk("auto_rearm_wr", {wr_en, wr_addr, wr_data}, {1'b1, 6'd0, 8'h5A});
        abort = 1; step(); abort = 0;
        chk("auto_abort_state", state, 0);
        auto_mode = 0;
        capture(0, 3'd0, 3'd0, 1, 0, -1, 0);
        frame_ack = 1; step(); frame_ack = 0;
        chk("single_ack_state", state, 4);

        for (int r = 0; r < 12; r++)
            capture(1'($urandom), 3'($urandom_range(7)), 3'($urandom_range(7)), 0, 0, -1, 1);

        // Abort with a simultaneous arm in POST: back to IDLE, no further writes.
        trigger_en = 0; arm = 1; step(); arm = 0;
        base = wq.size();
        for (int i = 0; i < 30; i++) begin
            clk_en = 1; data_in = 8'($urandom); step();
        end
        chk("abort_pre_state", state, 3);
        abort = 1; arm = 1; clk_en = 1; step();
        abort = 0; arm = 0;
        chk("abort_state", state, 0);
        for (int i = 0; i < 5; i++) step();
        clk_en = 0; step();
        chk("abort_writes", wq.size() - base, 30);

        // Asynchronous reset while waiting for a trigger that can never fire.
        trigger_en = 1; mode_sel = 3'd5; arm = 1; step(); arm = 0;
        for (int i = 0; i < 20; i++) begin
            clk_en = 1; data_in = 8'($urandom); step();
        end
        chk("wait_state", state, 2);
        #2 rst_n = 0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_flags", {busy, done, wr_en}, 0);
        chk("arst_wr", {wr_addr, wr_data}, 0);
        chk("arst_addrs", {trig_addr, start_addr}, 0);
        clk_en = 0;
        step();
        rst_n = 1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
